// File: rtl/as_gpio_ctrl.sv
// as_gpio_ctrl: register-mapped GPIO controller with a two-state bus handshake and a chip-select strobe.
// Optional edge interrupts are built in when AS_GPIO_IRQ_EN is defined; otherwise irq_o is tied 0.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i, we_i          bus request (held until ack_o), write enable
//   addr_i, wdata_i      byte address (bits [4:2] select the register), write data
//   rdata_o, ack_o       read data (zero outside ack_o), one-cycle completion pulse
//   gpio_io              pins, driven from DATA_OUT where DIR=1, high-Z elsewhere
//   cs_o                 one-cycle strobe coincident with ack_o on every DATA_OUT write
//   irq_o                level interrupt, |(IRQ_PEND & IRQ_MASK)
// Register map (addr[4:2]): 0 DATA_OUT, 1 DIR, 2 DATA_IN, 3 CS_CNT, 4 IRQ_MASK, 5 IRQ_PEND (w1c).
module as_gpio_ctrl #(
    parameter int NR_GPIOS = 8,
    parameter int ADDR_W   = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                ack_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o
);
    typedef enum logic {IDLE, ACK} state_e;
    state_e state_q, state_d;
    logic [NR_GPIOS-1:0] dout_q, dout_d, dir_q, dir_d, sync1_q, sync2_q;
    logic [NR_GPIOS-1:0] irq_mask, irq_pend, wd;
    logic [15:0]         cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d, rmux;
    logic                cs_q, cs_d, acc, wr, rd;
    logic [2:0]          sel;
    logic                unused_bits;
    assign unused_bits = ^{addr_i, wdata_i};
    assign sel = addr_i[4:2];
    assign wd  = wdata_i[NR_GPIOS-1:0];
    assign acc = (state_q == IDLE) && req_i;
    assign wr  = acc && we_i;
    assign rd  = acc && !we_i;
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (req_i ? ACK : IDLE) : IDLE;
    end
    always_comb begin
        rmux = '0;
        case (sel)
            3'd0:    rmux = 32'(dout_q);
            3'd1:    rmux = 32'(dir_q);
            3'd2:    rmux = 32'(sync2_q);
            3'd3:    rmux = 32'(cnt_q);
            3'd4:    rmux = 32'(irq_mask);
            3'd5:    rmux = 32'(irq_pend);
            default: rmux = '0;
        endcase
    end
    always_comb begin
        dout_d  = (wr && sel == 3'd0) ? wd : dout_q;
        dir_d   = (wr && sel == 3'd1) ? wd : dir_q;
        cs_d    = wr && sel == 3'd0;
        cnt_d   = cnt_q + 16'(cs_d);
        rdata_d = rd ? rmux : '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dout_q  <= '0;
            dir_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            sync1_q <= gpio_io;
            sync2_q <= sync1_q;
        end
    end
    assign ack_o   = state_q == ACK;
    assign rdata_o = ack_o ? rdata_q : '0;
    assign cs_o    = cs_q;
    // Each bit drives straight from registers, so a high-Z bit can never glitch-drive.
    for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
        assign gpio_io[i] = dir_q[i] ? dout_q[i] : 1'bz;
    end
`ifdef AS_GPIO_IRQ_EN
    logic [NR_GPIOS-1:0] mask_q, mask_d, pend_q, pend_d, prev_q;
    logic                irq_q, irq_d;
    // Set is OR-ed after the w1c clear so a same-cycle edge wins.
    always_comb begin
        mask_d = (wr && sel == 3'd4) ? wd : mask_q;
        pend_d = (pend_q & ~((wr && sel == 3'd5) ? wd : '0)) | (sync2_q & ~prev_q);
        irq_d  = |(pend_d & mask_d);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
            prev_q <= sync2_q;
            irq_q  <= irq_d;
        end
    end
    assign irq_mask = mask_q;
    assign irq_pend = pend_q;
    assign irq_o    = irq_q;
`else
    assign irq_mask = '0;
    assign irq_pend = '0;
    assign irq_o    = 1'b0;
`endif
endmodule
